// File: rtl/eqy_seq_miter_monitor.sv
// eqy_seq_miter_monitor: multi-channel sequential gold/gate miter with settle window and sticky first-fail capture
module eqy_seq_miter_monitor #(
   parameter int WIDTH         = 32,
   parameter int CHANNELS      = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16,
   parameter bit STOP_ON_FAIL  = 1'b1,
   localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clear,
   input  logic [CHANNELS-1:0]       ch_en,
   input  logic [CHANNELS-1:0]       valid,
   input  logic [CHANNELS*WIDTH-1:0] gold,
   input  logic [CHANNELS*WIDTH-1:0] gate,
   input  logic [CHANNELS*WIDTH-1:0] gold_xmask,
   output logic                      fail,
   output logic [CHANNELS-1:0]       fail_ch,
   output logic [CH_W-1:0]           first_ch,
   output logic [WIDTH-1:0]          first_diff,
   output logic [CNT_W-1:0]          first_cycle,
   output logic [CNT_W-1:0]          mismatch_cnt,
   output logic [CNT_W-1:0]          check_cycles,
   output logic [1:0]                state
);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_FAIL} st_t;
   st_t st;
   logic [SW-1:0] cnt;
   logic [CHANNELS-1:0] hit;
   logic [CH_W-1:0] sel;
   logic [WIDTH-1:0] sel_diff, d;
   logic any_hit;
   assign state = st;
   assign fail = |fail_ch;
   assign any_hit = |hit;
   // per-channel masked compare; descending scan so the lowest hitting channel wins
   always_comb begin
      hit = '0;
      sel = '0;
      sel_diff = '0;
      d = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         d = (gold[c*WIDTH +: WIDTH] ^ gate[c*WIDTH +: WIDTH]) & ~gold_xmask[c*WIDTH +: WIDTH];
         hit[c] = (st == S_CHECK) & valid[c] & ch_en[c] & (|d);
         if (hit[c]) begin
            sel = CH_W'(c);
            sel_diff = d;
         end
      end
   end
   // arm/settle/check FSM with sticky result capture and saturating counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= S_IDLE;
         cnt <= '0;
         fail_ch <= '0;
         first_ch <= '0;
         first_diff <= '0;
         first_cycle <= '0;
         mismatch_cnt <= '0;
         check_cycles <= '0;
      end else if (clear) begin
         st <= S_IDLE;
         cnt <= '0;
         fail_ch <= '0;
         first_ch <= '0;
         first_diff <= '0;
         first_cycle <= '0;
         mismatch_cnt <= '0;
         check_cycles <= '0;
      end else begin
         if (st == S_CHECK && check_cycles != '1) check_cycles <= check_cycles + CNT_W'(1);
         if (any_hit) begin
            fail_ch <= fail_ch | hit;
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (!fail) begin
               first_ch <= sel;
               first_diff <= sel_diff;
               first_cycle <= check_cycles;
            end
         end
         case (st)
            S_IDLE: if (en) begin
               st <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
               cnt <= SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
            end
            S_SETTLE: if (!en) st <= S_IDLE;
               else if (cnt == '0) st <= S_CHECK;
               else cnt <= cnt - SW'(1);
            S_CHECK: if (!en) st <= S_IDLE;
               else if (any_hit && STOP_ON_FAIL) st <= S_FAIL;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_eqy_seq_miter_monitor.sv
// tb_eqy_seq_miter_monitor: randomized and directed checks of two monitor instances against a behavioural model
module tb_eqy_seq_miter_monitor;
   localparam int SETTLE = 2;
   logic clk = 0, rst = 1, en = 0, clear = 0;
   logic [3:0] ch_en = 0, valid = 0;
   logic [127:0] gold = 0, gate = 0, xmask = 0;
   logic fail1, fail2;
   logic [3:0] fail_ch1, fail_ch2;
   logic [1:0] first_ch1, first_ch2, state1, state2;
   logic [31:0] first_diff1, first_diff2;
   logic [15:0] first_cycle1, mcnt1, ccyc1;
   logic [3:0] first_cycle2, mcnt2, ccyc2;
   logic [88:0] v1, v2;
   int ncmp = 0, nerr = 0;
   typedef struct {
      int armed;
      bit halted;
      logic [3:0] fch;
      int fc;
      logic [31:0] fd;
      int fcy;
      int mc;
      int cc;
   } m_t;
   m_t m1, m2, z;
   always #5 clk = ~clk;
   eqy_seq_miter_monitor dut1 (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .ch_en(ch_en), .valid(valid),
      .gold(gold), .gate(gate), .gold_xmask(xmask), .fail(fail1), .fail_ch(fail_ch1),
      .first_ch(first_ch1), .first_diff(first_diff1), .first_cycle(first_cycle1),
      .mismatch_cnt(mcnt1), .check_cycles(ccyc1), .state(state1));
   eqy_seq_miter_monitor #(.CNT_W(4), .STOP_ON_FAIL(1'b0)) dut2 (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .ch_en(ch_en), .valid(valid),
      .gold(gold), .gate(gate), .gold_xmask(xmask), .fail(fail2), .fail_ch(fail_ch2),
      .first_ch(first_ch2), .first_diff(first_diff2), .first_cycle(first_cycle2),
      .mismatch_cnt(mcnt2), .check_cycles(ccyc2), .state(state2));
   assign v1 = {fail1, fail_ch1, first_ch1, first_diff1, first_cycle1, mcnt1, ccyc1, state1};
   assign v2 = {fail2, fail_ch2, first_ch2, first_diff2, 12'(0), first_cycle2, 12'(0), mcnt2, 12'(0), ccyc2, state2};
   // state derived from how long the monitor has been continuously armed
   function automatic int st_of(m_t m);
      return m.halted ? 3 : (m.armed == 0) ? 0 : (m.armed <= SETTLE) ? 1 : 2;
   endfunction
   function automatic logic [88:0] pack(m_t m);
      return {m.fch != 0, m.fch, 2'(m.fc), m.fd, 16'(m.fcy), 16'(m.mc), 16'(m.cc), 2'(st_of(m))};
   endfunction
   function automatic m_t step(m_t m, bit stop, int cmax);
      m_t n = m;
      logic [31:0] d, dfirst = 0;
      logic [3:0] h = 0;
      int first = -1;
      int st = st_of(m);
      if (clear) return z;
      for (int c = 0; c < 4; c++) begin
         d = (gold[c*32 +: 32] ^ gate[c*32 +: 32]) & ~xmask[c*32 +: 32];
         if (st == 2 && valid[c] && ch_en[c] && d != 0) begin
            h[c] = 1;
            if (first < 0) begin
               first = c;
               dfirst = d;
            end
         end
      end
      if (st == 2) n.cc = (m.cc < cmax) ? m.cc + 1 : cmax;
      if (h != 0) begin
         n.fch = m.fch | h;
         n.mc = (m.mc < cmax) ? m.mc + 1 : cmax;
         if (m.fch == 0) begin
            n.fc = first;
            n.fd = dfirst;
            n.fcy = m.cc;
         end
      end
      if (!m.halted) begin
         n.armed = !en ? 0 : (m.armed > SETTLE) ? m.armed : m.armed + 1;
         if (st == 2 && en && h != 0 && stop) n.halted = 1;
      end
      return n;
   endfunction
   task automatic tick();
      m_t n1, n2;
      n1 = step(m1, 1, 65535);
      n2 = step(m2, 0, 15);
      @(posedge clk);
      #1;
      m1 = n1;
      m2 = n2;
   endtask
   task automatic set_match();
      for (int c = 0; c < 4; c++) gold[c*32 +: 32] = $urandom;
      gate = gold;
      xmask = 0;
      valid = 4'hF;
      ch_en = 4'hF;
   endtask
   task automatic do_clear();
      clear = 1;
      tick();
      clear = 0;
   endtask
   task automatic arm();
      set_match();
      en = 1;
      repeat (SETTLE + 1) tick();
   endtask
   task automatic test_reset();
      ncmp++;
      if (v1 !== 0 || v2 !== 0) begin
         nerr++;
         $display("FAIL reset_init dut1 %h dut2 %h want 0", v1, v2);
      end
      arm();
      gate[32 +: 32] = ~gold[32 +: 32];
      tick();
      ncmp++;
      if (fail2 !== 1'b1 || state2 !== 2'd2 || v2 !== pack(m2)) begin
         nerr++;
         $display("FAIL pre_rst_fail dut2 %h want %h", v2, pack(m2));
      end
      #3 rst = 1;
      #1;
      m1 = z;
      m2 = z;
      ncmp++;
      if (v1 !== 0 || v2 !== 0) begin
         nerr++;
         $display("FAIL async_rst dut1 %h dut2 %h want 0", v1, v2);
      end
      #1 rst = 0;
      en = 0;
      tick();
   endtask
   task automatic test_settle();
      logic [1:0] exp_st [3] = '{2'd1, 2'd1, 2'd2};
      do_clear();
      set_match();
      gate = ~gold;
      en = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) gate = gold;
         tick();
         ncmp++;
         if (state1 !== exp_st[i] || fail1 !== 1'b0 || v1 !== pack(m1) || v2 !== pack(m2)) begin
            nerr++;
            $display("FAIL settle_%0d state %0d fail %b want state %0d fail 0", i, state1, fail1, exp_st[i]);
         end
      end
   endtask
   task automatic test_first_fail();
      do_clear();
      arm();
      for (int i = 0; i < 20 && m1.cc != 5; i++) tick();
      gold[64 +: 32] = 32'hA5;
      gate[64 +: 32] = 32'hA4;
      tick();
      ncmp++;
      if (fail_ch1 !== 4'b0100 || first_ch1 !== 2'd2 || first_diff1 !== 32'h1 || first_cycle1 !== 16'd5
          || mcnt1 !== 16'd1 || state1 !== 2'd3) begin
         nerr++;
         $display("FAIL first_fail fch %b ch %0d diff %h cyc %0d mc %0d st %0d want 0100 2 1 5 1 3",
                  fail_ch1, first_ch1, first_diff1, first_cycle1, mcnt1, state1);
      end
      ncmp++;
      if (v1 !== pack(m1) || v2 !== pack(m2)) begin
         nerr++;
         $display("FAIL first_fail_model dut1 %h want %h dut2 %h want %h", v1, pack(m1), v2, pack(m2));
      end
      set_match();
      en = 0;
      repeat (3) tick();
      ncmp++;
      if (state1 !== 2'd3 || first_cycle1 !== 16'd5 || v1 !== pack(m1)) begin
         nerr++;
         $display("FAIL fail_hold state %0d cyc %0d want 3 5", state1, first_cycle1);
      end
   endtask
   task automatic test_mask();
      for (int k = 0; k < 4; k++) begin
         do_clear();
         arm();
         gold[64 +: 32] = 32'hA5;
         gate[64 +: 32] = 32'hA4;
         if (k == 0) xmask[64 +: 32] = 32'h1;
         if (k == 1) ch_en[2] = 0;
         if (k == 2) valid[2] = 0;
         if (k == 3) begin
            gold[64 +: 32] = 32'hxxxx_xxA5;
            gate[64 +: 32] = 32'h0000_00A5;
            xmask[64 +: 32] = 32'hFFFF_FF00;
            gold[0 +: 32] = 'x;
            valid[0] = 0;
         end
         repeat (2) tick();
         ncmp++;
         if (fail1 !== 1'b0 || fail2 !== 1'b0 || state1 !== 2'd2 || v1 !== pack(m1) || v2 !== pack(m2)) begin
            nerr++;
            $display("FAIL mask_%0d fail1 %b fail2 %b state %0d want 0 0 2", k, fail1, fail2, state1);
         end
      end
      set_match();
   endtask
   task automatic test_multi();
      do_clear();
      arm();
      for (int i = 0; i < 3; i++) begin
         gate[32 +: 32] = gold[32 +: 32] ^ (32'h1 << i);
         gate[96 +: 32] = gold[96 +: 32] ^ 32'h8000_0000;
         tick();
      end
      ncmp++;
      if (first_ch2 !== 2'd1 || fail_ch2 !== 4'b1010 || mcnt2 !== 4'd3 || state2 !== 2'd2 || first_diff2 !== 32'h1) begin
         nerr++;
         $display("FAIL multi ch %0d fch %b mc %0d st %0d diff %h want 1 1010 3 2 1",
                  first_ch2, fail_ch2, mcnt2, state2, first_diff2);
      end
      ncmp++;
      if (v1 !== pack(m1) || v2 !== pack(m2)) begin
         nerr++;
         $display("FAIL multi_model dut1 %h want %h dut2 %h want %h", v1, pack(m1), v2, pack(m2));
      end
   endtask
   task automatic test_saturate();
      do_clear();
      arm();
      gate[0 +: 32] = ~gold[0 +: 32];
      repeat (20) tick();
      ncmp++;
      if (mcnt2 !== 4'd15 || ccyc2 !== 4'd15 || v2 !== pack(m2)) begin
         nerr++;
         $display("FAIL saturate mc %0d cc %0d want 15 15", mcnt2, ccyc2);
      end
      clear = 1;
      tick();
      clear = 0;
      ncmp++;
      if (v1 !== 0 || v2 !== 0 || state2 !== 2'd0) begin
         nerr++;
         $display("FAIL clear_with_hit dut1 %h dut2 %h want 0", v1, v2);
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en = $urandom_range(0, 11) != 0;
         clear = $urandom_range(0, 59) == 0;
         valid = 4'($urandom);
         ch_en = 4'($urandom);
         for (int c = 0; c < 4; c++) begin
            gold[c*32 +: 32] = $urandom;
            gate[c*32 +: 32] = gold[c*32 +: 32] ^ (($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
            xmask[c*32 +: 32] = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'h0;
         end
         tick();
         ncmp++;
         if (v1 !== pack(m1) || v2 !== pack(m2)) begin
            nerr++;
            $display("FAIL random_%0d dut1 %h want %h dut2 %h want %h", i, v1, pack(m1), v2, pack(m2));
         end
      end
      clear = 0;
   endtask
   initial begin
      z = '{default: 0};
      m1 = z;
      m2 = z;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      test_reset();
      test_settle();
      test_first_fail();
      test_mask();
      test_multi();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
